pwm_cfg_scheduler: RTL



---
 rtl/pwm_cfg_pkg.sv | 35 +++
 rtl/pwm_cfg_loader.sv | 118 +++++++++++
 rtl/pwm_cfg_scheduler.sv | 95 +++++++++
 3 files changed

// File: rtl/pwm_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_pkg
// Description : Shared types and constants for the PWM scheduler and its
//               byte-serial configuration loader.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_cfg_pkg;

    // Default period loaded into the active and shadow registers at reset
    localparam int RST_PERIOD_DEF = 255;

    // Header byte field positions: [7:6] command, [1:0] channel
    localparam int HDR_CMD_MSB = 7;
    localparam int HDR_CMD_LSB = 6;
    localparam int HDR_CH_MSB  = 1;
    localparam int HDR_CH_LSB  = 0;

    // Header command codes
    typedef enum logic [1:0] {
        CMD_DUTY   = 2'b00,
        CMD_PERIOD = 2'b01,
        CMD_COMMIT = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_e;

    // Loader FSM state encoding
    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_e;
    localparam state_e S_HDR  = 2'd0;
    localparam state_e S_DATA = 2'd1;
    localparam state_e S_PEND = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwm_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_loader
// Description : Header/data command FSM. Holds shadow period and duty
//               registers and the commit-pending flag; returns to header
//               state when the top signals the apply event.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cfg_loader
    import pwm_cfg_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int RST_PERIOD = RST_PERIOD_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    input  logic [7:0]                     cfg_data,
    input  logic                           apply,
    output logic                           cfg_ready,
    output logic                           cmd_err,
    output logic                           commit_pending,
    output logic [CNT_W-1:0]               shadow_period,
    output logic [NUM_CH-1:0][CNT_W-1:0]   shadow_duty
);

    state_e                       r_state;
    cmd_e                         r_cmd;
    logic [1:0]                   r_ch;
    logic                         r_commit_pending;
    logic                         r_cmd_err;
    logic [CNT_W-1:0]             r_shadow_period;
    logic [NUM_CH-1:0][CNT_W-1:0] r_shadow_duty;

    cmd_e       w_cmd;
    logic [1:0] w_ch;
    logic       w_ch_bad;
    logic       w_unused;

    assign w_cmd    = cmd_e'(cfg_data[HDR_CMD_MSB:HDR_CMD_LSB]);
    assign w_ch     = cfg_data[HDR_CH_MSB:HDR_CH_LSB];
    assign w_ch_bad = ({30'd0, w_ch} >= 32'(NUM_CH));
    // Header bits [5:2] carry no meaning
    assign w_unused = ^cfg_data[5:2];

    // Ready in header/data states only, and never while reset is held
    assign cfg_ready      = !rst && (r_state != S_PEND);
    assign cmd_err        = r_cmd_err;
    assign commit_pending = r_commit_pending;
    assign shadow_period  = r_shadow_period;
    assign shadow_duty    = r_shadow_duty;

    // Command FSM: decode headers, capture data into shadows, wait for apply
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_HDR;
            r_cmd            <= CMD_DUTY;
            r_ch             <= 2'd0;
            r_commit_pending <= 1'b0;
            r_cmd_err        <= 1'b0;
            r_shadow_period  <= CNT_W'(RST_PERIOD);
            r_shadow_duty    <= '0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (cfg_valid) begin
                        case (w_cmd)
                            CMD_DUTY: begin
                                if (w_ch_bad) begin
                                    r_cmd_err <= 1'b1;
                                end else begin
                                    r_cmd   <= w_cmd;
                                    r_ch    <= w_ch;
                                    r_state <= S_DATA;
                                end
                            end
                            CMD_PERIOD: begin
                                r_cmd   <= w_cmd;
                                r_ch    <= w_ch;
                                r_state <= S_DATA;
                            end
                            CMD_COMMIT: begin
                                r_commit_pending <= 1'b1;
                                r_state          <= S_PEND;
                            end
                            default: r_cmd_err <= 1'b1;
                        endcase
                    end
                end
                S_DATA: begin
                    if (cfg_valid) begin
                        if (r_cmd == CMD_PERIOD) begin
                            r_shadow_period <= cfg_data[CNT_W-1:0];
                        end else begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (r_ch == 2'(i)) begin
                                    r_shadow_duty[i] <= cfg_data[CNT_W-1:0];
                                end
                            end
                        end
                        r_state <= S_HDR;
                    end
                end
                S_PEND: begin
                    if (apply) begin
                        r_commit_pending <= 1'b0;
                        r_state          <= S_HDR;
                    end
                end
                default: r_state <= S_HDR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_cfg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_scheduler
// Description : Multi-channel PWM with one shared period counter. Shadow
//               configuration from the loader is copied into the active
//               registers atomically at a period boundary (or immediately
//               when the counter is disabled).
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cfg_scheduler
    import pwm_cfg_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int RST_PERIOD = RST_PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [7:0]        cfg_data,
    output logic              cfg_ready,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              period_start,
    output logic              commit_done,
    output logic              cmd_err
);

    logic [CNT_W-1:0]             r_cnt;
    logic [CNT_W-1:0]             r_period_active;
    logic [NUM_CH-1:0][CNT_W-1:0] r_duty_active;
    logic [NUM_CH-1:0]            r_pwm;
    logic                         r_period_start;
    logic                         r_commit_done;

    logic                         w_commit_pending;
    logic [CNT_W-1:0]             w_shadow_period;
    logic [NUM_CH-1:0][CNT_W-1:0] w_shadow_duty;
    logic                         w_wrap;
    logic                         w_apply;

    pwm_cfg_loader #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .RST_PERIOD (RST_PERIOD)
    ) u_loader (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_data       (cfg_data),
        .apply          (w_apply),
        .cfg_ready      (cfg_ready),
        .cmd_err        (cmd_err),
        .commit_pending (w_commit_pending),
        .shadow_period  (w_shadow_period),
        .shadow_duty    (w_shadow_duty)
    );

    assign w_wrap = (r_cnt == r_period_active);
    // While running, apply waits for the wrap so no period is cut short
    assign w_apply = w_commit_pending && (enable ? w_wrap : 1'b1);

    assign pwm_o        = r_pwm;
    assign period_start = r_period_start;
    assign commit_done  = r_commit_done;

    // Counter, atomic shadow-to-active transfer and registered comparators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_period_active <= CNT_W'(RST_PERIOD);
            r_duty_active   <= '0;
            r_pwm           <= '0;
            r_period_start  <= 1'b0;
            r_commit_done   <= 1'b0;
        end else begin
            if (enable && !w_wrap) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            r_period_start <= enable && w_wrap;
            r_commit_done  <= w_apply;
            if (w_apply) begin
                r_period_active <= w_shadow_period;
                r_duty_active   <= w_shadow_duty;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                r_pwm[i] <= enable && (r_cnt < r_duty_active[i]);
            end
        end
    end

endmodule
`default_nettype wire
